// File: rtl/mdio_phy_responder.sv
// Clause-22 MDIO target for a single PHY address. It decodes frames sampled from a
// synchronized mdc/mdi and exposes extended regs 0xA001/0xA003 through indirect regs 0x1E/0x1F.
module mdio_phy_responder #(
  parameter logic [4:0]  PHY_ADDR = 5'b00001,
  parameter int          PRE_MIN  = 32,
  parameter logic [15:0] PHY_ID1  = 16'h001C,
  parameter logic [15:0] PHY_ID2  = 16'hC916,
  parameter logic [15:0] A001_RST = 16'h0000,
  parameter logic [15:0] A003_RST = 16'h0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mdc,
  input  logic        mdi,
  output logic        mdo,
  output logic        mdt,
  output logic [15:0] ext_a001,
  output logic [15:0] ext_a003,
  output logic        rxc_2ns,
  output logic [3:0]  rxc_dlysel,
  output logic        ext_wr_stb
);

  localparam int PW = $clog2(PRE_MIN + 1);
  localparam logic [PW-1:0] PRE_SAT = PW'(PRE_MIN);

  typedef enum logic [2:0] {S_IDLE, S_ST, S_OP, S_PHYAD, S_REGAD, S_TA, S_DATA} state_t;

  state_t        state_q, state_d;
  logic [2:0]    mdc_sync_q, mdc_sync_d;
  logic [1:0]    mdi_sync_q, mdi_sync_d;
  logic [PW-1:0] pre_cnt_q, pre_cnt_d;
  logic [3:0]    bit_cnt_q, bit_cnt_d;
  logic          op_rd_q, op_rd_d;
  logic [3:0]    phyad_q, phyad_d;
  logic [4:0]    regad_q, regad_d;
  logic          match_q, match_d;
  logic [15:0]   rd_sh_q, rd_sh_d;
  logic [15:0]   wr_sh_q, wr_sh_d;
  logic          wr_pend_q, wr_pend_d;
  logic [15:0]   ext_addr_q, ext_addr_d;
  logic [15:0]   a001_q, a001_d;
  logic [15:0]   a003_q, a003_d;
  logic          stb_q, stb_d;
  logic          mdo_q, mdo_d;
  logic          mdt_q, mdt_d;

  logic          mdc_rise, mdc_fall, mdi_s;
  logic [4:0]    regad_full;
  logic [15:0]   rd_val;

  // mdc and mdi share the same synchronizer depth, so mdi_s is aligned with the detected edge.
  assign mdc_rise   = mdc_sync_q[1] & ~mdc_sync_q[2];
  assign mdc_fall   = ~mdc_sync_q[1] & mdc_sync_q[2];
  assign mdi_s      = mdi_sync_q[1];
  assign regad_full = {regad_q[3:0], mdi_s};

  always_comb begin
    rd_val = 16'h0000;
    case (regad_full)
      5'h02: rd_val = PHY_ID1;
      5'h03: rd_val = PHY_ID2;
      5'h1E: rd_val = ext_addr_q;
      5'h1F: begin
        if (ext_addr_q == 16'hA001)      rd_val = a001_q;
        else if (ext_addr_q == 16'hA003) rd_val = a003_q;
      end
      default: rd_val = 16'h0000;
    endcase
  end

  always_comb begin
    mdc_sync_d = {mdc_sync_q[1:0], mdc};
    mdi_sync_d = {mdi_sync_q[0], mdi};
    state_d    = state_q;
    pre_cnt_d  = pre_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    op_rd_d    = op_rd_q;
    phyad_d    = phyad_q;
    regad_d    = regad_q;
    match_d    = match_q;
    rd_sh_d    = rd_sh_q;
    wr_sh_d    = wr_sh_q;
    wr_pend_d  = 1'b0;
    ext_addr_d = ext_addr_q;
    a001_d     = a001_q;
    a003_d     = a003_q;
    stb_d      = 1'b0;
    mdo_d      = mdo_q;
    mdt_d      = mdt_q;

    // Write commit runs one clk after the D0 rise; regad_q still holds the frame's address.
    if (wr_pend_q) begin
      if (regad_q == 5'h1E) begin
        ext_addr_d = wr_sh_q;
      end else if (regad_q == 5'h1F) begin
        if (ext_addr_q == 16'hA001) begin
          a001_d = wr_sh_q;
          stb_d  = 1'b1;
        end else if (ext_addr_q == 16'hA003) begin
          a003_d = wr_sh_q;
          stb_d  = 1'b1;
        end
      end
    end

    if (mdc_rise) begin
      case (state_q)
        S_IDLE: begin
          if (mdi_s) begin
            if (pre_cnt_q != PRE_SAT) pre_cnt_d = pre_cnt_q + PW'(1);
          end else begin
            pre_cnt_d = '0;
            if (pre_cnt_q >= PRE_SAT) state_d = S_ST;
          end
        end
        S_ST: begin
          bit_cnt_d = 4'd0;
          state_d   = mdi_s ? S_OP : S_IDLE;
        end
        S_OP: begin
          if (bit_cnt_q == 4'd0) begin
            op_rd_d   = mdi_s;
            bit_cnt_d = 4'd1;
          end else begin
            bit_cnt_d = 4'd0;
            state_d   = (op_rd_q != mdi_s) ? S_PHYAD : S_IDLE;
          end
        end
        S_PHYAD: begin
          phyad_d = {phyad_q[2:0], mdi_s};
          if (bit_cnt_q == 4'd4) begin
            match_d   = ({phyad_q, mdi_s} == PHY_ADDR);
            bit_cnt_d = 4'd0;
            state_d   = S_REGAD;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_REGAD: begin
          regad_d = regad_full;
          if (bit_cnt_q == 4'd4) begin
            rd_sh_d   = rd_val;
            bit_cnt_d = 4'd0;
            state_d   = S_TA;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        S_TA: begin
          if (bit_cnt_q == 4'd1) begin
            bit_cnt_d = 4'd0;
            state_d   = S_DATA;
          end else begin
            bit_cnt_d = 4'd1;
          end
        end
        S_DATA: begin
          wr_sh_d = {wr_sh_q[14:0], mdi_s};
          if (bit_cnt_q == 4'd15) begin
            state_d   = S_IDLE;
            wr_pend_d = match_q & ~op_rd_q;
          end else begin
            bit_cnt_d = bit_cnt_q + 4'd1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end

    // The line is driven only between the TA0 rise and the D0 rise of a matching read.
    if (mdc_fall) begin
      if (match_q && op_rd_q && state_q == S_TA && bit_cnt_q == 4'd1) begin
        mdo_d = 1'b0;
        mdt_d = 1'b0;
      end else if (match_q && op_rd_q && state_q == S_DATA) begin
        mdo_d   = rd_sh_q[15];
        mdt_d   = 1'b0;
        rd_sh_d = {rd_sh_q[14:0], 1'b0};
      end else begin
        mdo_d = 1'b1;
        mdt_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      mdc_sync_q <= '0;
      mdi_sync_q <= '0;
      pre_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      op_rd_q    <= 1'b0;
      phyad_q    <= '0;
      regad_q    <= '0;
      match_q    <= 1'b0;
      rd_sh_q    <= '0;
      wr_sh_q    <= '0;
      wr_pend_q  <= 1'b0;
      ext_addr_q <= '0;
      a001_q     <= A001_RST;
      a003_q     <= A003_RST;
      stb_q      <= 1'b0;
      mdo_q      <= 1'b1;
      mdt_q      <= 1'b1;
    end else begin
      state_q    <= state_d;
      mdc_sync_q <= mdc_sync_d;
      mdi_sync_q <= mdi_sync_d;
      pre_cnt_q  <= pre_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      op_rd_q    <= op_rd_d;
      phyad_q    <= phyad_d;
      regad_q    <= regad_d;
      match_q    <= match_d;
      rd_sh_q    <= rd_sh_d;
      wr_sh_q    <= wr_sh_d;
      wr_pend_q  <= wr_pend_d;
      ext_addr_q <= ext_addr_d;
      a001_q     <= a001_d;
      a003_q     <= a003_d;
      stb_q      <= stb_d;
      mdo_q      <= mdo_d;
      mdt_q      <= mdt_d;
    end
  end

  assign mdo        = mdo_q;
  assign mdt        = mdt_q;
  assign ext_a001   = a001_q;
  assign ext_a003   = a003_q;
  assign rxc_2ns    = a001_q[8];
  assign rxc_dlysel = a003_q[13:10];
  assign ext_wr_stb = stb_q;

endmodule

// File: tb/tb_mdio_phy_responder.sv
// Directed bench for mdio_phy_responder: a table of MDIO frames with hand-computed results,
// plus sequences for an illegal opcode and a reset asserted in the middle of a read.
module tb_mdio_phy_responder;

  logic        clk, rst, mdc, mdi;
  logic        mdo, mdt, rxc_2ns, ext_wr_stb;
  logic [15:0] ext_a001, ext_a003;
  logic [3:0]  rxc_dlysel;

  int tests = 0;
  int fails = 0;
  int stb_cnt = 0;

  mdio_phy_responder dut (
    .clk(clk), .rst(rst), .mdc(mdc), .mdi(mdi), .mdo(mdo), .mdt(mdt),
    .ext_a001(ext_a001), .ext_a003(ext_a003), .rxc_2ns(rxc_2ns),
    .rxc_dlysel(rxc_dlysel), .ext_wr_stb(ext_wr_stb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) if (ext_wr_stb === 1'b1) stb_cnt = stb_cnt + 1;

  typedef struct {
    int          pre_n;
    logic [1:0]  op;
    logic [4:0]  phy;
    logic [4:0]  ra;
    logic [15:0] wd;
    logic        drive;
    logic [15:0] exp_rd;
    logic [15:0] exp_a001;
    logic [15:0] exp_a003;
    int          exp_stb;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // One mdc period: 80 ns low (master updates mdi), 80 ns high; line sampled just before the rise.
  task automatic bitx(input logic b, output logic o, output logic t);
    mdc = 1'b0; mdi = b;
    #80;
    o = mdo; t = mdt;
    mdc = 1'b1;
    #80;
  endtask

  task automatic frame(input int pre_n, input logic [1:0] op, input logic [4:0] phy,
                       input logic [4:0] ra, input logic [15:0] wd,
                       output logic [15:0] rd, output logic drove, output logic ta0_t,
                       output logic ta1_o, output logic ta1_t, output logic rel_t);
    logic o, t;
    logic [13:0] hdr;
    logic rdop;
    hdr = {2'b01, op, phy, ra};
    rdop = (op == 2'b10);
    drove = 1'b0;
    rd = '0;
    for (int i = 0; i < pre_n; i++) begin bitx(1'b1, o, t); if (!t) drove = 1'b1; end
    for (int i = 13; i >= 0; i--) begin bitx(hdr[i], o, t); if (!t) drove = 1'b1; end
    bitx(1'b1, o, ta0_t); if (!ta0_t) drove = 1'b1;
    bitx(rdop ? 1'b1 : 1'b0, ta1_o, ta1_t); if (!ta1_t) drove = 1'b1;
    for (int i = 15; i >= 0; i--) begin
      bitx(rdop ? 1'b1 : wd[i], o, t);
      rd[i] = o;
      if (!t) drove = 1'b1;
    end
    mdc = 1'b0; mdi = 1'b1;
    #80;
    rel_t = mdt;
  endtask

  initial begin
    logic [15:0] rd;
    logic drove, ta0_t, ta1_o, ta1_t, rel_t, o, t;
    logic [13:0] hdr;

    //          pre op     phy    ra     wdata     drv   rd        a001      a003      stb
    vecs.push_back('{32, 2'b01, 5'h01, 5'h1E, 16'hA001, 1'b0, 16'h0000, 16'h0000, 16'h0000, 0});
    vecs.push_back('{32, 2'b01, 5'h01, 5'h1F, 16'h0100, 1'b0, 16'h0000, 16'h0100, 16'h0000, 1});
    vecs.push_back('{32, 2'b01, 5'h01, 5'h1E, 16'hA003, 1'b0, 16'h0000, 16'h0100, 16'h0000, 0});
    vecs.push_back('{32, 2'b01, 5'h01, 5'h1F, 16'h3C00, 1'b0, 16'h0000, 16'h0100, 16'h3C00, 1});
    vecs.push_back('{32, 2'b10, 5'h01, 5'h1F, 16'h0000, 1'b1, 16'h3C00, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b10, 5'h01, 5'h1E, 16'h0000, 1'b1, 16'hA003, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h001C, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b10, 5'h02, 5'h02, 16'h0000, 1'b0, 16'h0000, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b10, 5'h01, 5'h03, 16'h0000, 1'b1, 16'hC916, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b01, 5'h02, 5'h1E, 16'hA001, 1'b0, 16'h0000, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b10, 5'h01, 5'h1E, 16'h0000, 1'b1, 16'hA003, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{31, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b0, 16'h0000, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h001C, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b01, 5'h01, 5'h1E, 16'h1234, 1'b0, 16'h0000, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b10, 5'h01, 5'h1F, 16'h0000, 1'b1, 16'h0000, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b01, 5'h01, 5'h1F, 16'hFFFF, 1'b0, 16'h0000, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b10, 5'h01, 5'h05, 16'h0000, 1'b1, 16'h0000, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b01, 5'h01, 5'h02, 16'hFFFF, 1'b0, 16'h0000, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b10, 5'h01, 5'h02, 16'h0000, 1'b1, 16'h001C, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b01, 5'h01, 5'h1E, 16'hA001, 1'b0, 16'h0000, 16'h0100, 16'h3C00, 0});
    vecs.push_back('{32, 2'b10, 5'h01, 5'h1F, 16'h0000, 1'b1, 16'h0100, 16'h0100, 16'h3C00, 0});

    rst = 1'b1; mdc = 1'b0; mdi = 1'b1;
    #33;
    check("rst_mdo", mdo, 1'b1);
    check("rst_mdt", mdt, 1'b1);
    check("rst_a001", ext_a001, 16'h0000);
    check("rst_a003", ext_a003, 16'h0000);
    check("rst_stb", ext_wr_stb, 1'b0);
    rst = 1'b0;
    #40;

    foreach (vecs[k]) begin
      stb_cnt = 0;
      frame(vecs[k].pre_n, vecs[k].op, vecs[k].phy, vecs[k].ra, vecs[k].wd,
            rd, drove, ta0_t, ta1_o, ta1_t, rel_t);
      if (vecs[k].drive) begin
        check($sformatf("v%0d_rdata", k), rd, vecs[k].exp_rd);
        check($sformatf("v%0d_ta0_mdt", k), ta0_t, 1'b1);
        check($sformatf("v%0d_ta1_mdo", k), ta1_o, 1'b0);
        check($sformatf("v%0d_ta1_mdt", k), ta1_t, 1'b0);
        check($sformatf("v%0d_release", k), rel_t, 1'b1);
      end else begin
        check($sformatf("v%0d_nodrive", k), drove, 1'b0);
      end
      check($sformatf("v%0d_a001", k), ext_a001, vecs[k].exp_a001);
      check($sformatf("v%0d_a003", k), ext_a003, vecs[k].exp_a003);
      check($sformatf("v%0d_rxc_2ns", k), rxc_2ns, vecs[k].exp_a001[8]);
      check($sformatf("v%0d_dlysel", k), rxc_dlysel, vecs[k].exp_a003[13:10]);
      check($sformatf("v%0d_stb", k), stb_cnt, vecs[k].exp_stb);
    end

    // Opcode 11 after a valid start must abort silently; the following frame still decodes.
    drove = 1'b0;
    for (int i = 0; i < 32; i++) begin bitx(1'b1, o, t); if (!t) drove = 1'b1; end
    bitx(1'b0, o, t); if (!t) drove = 1'b1;
    bitx(1'b1, o, t); if (!t) drove = 1'b1;
    bitx(1'b1, o, t); if (!t) drove = 1'b1;
    bitx(1'b1, o, t); if (!t) drove = 1'b1;
    mdc = 1'b0; #80;
    check("op11_nodrive", drove, 1'b0);
    check("op11_mdt", mdt, 1'b1);
    frame(32, 2'b10, 5'h01, 5'h03, 16'h0000, rd, drove, ta0_t, ta1_o, ta1_t, rel_t);
    check("after_op11_rdata", rd, 16'hC916);
    check("after_op11_ta1", ta1_t, 1'b0);

    // Reset while the PHY is driving data bit 8 of a read of reg 0x02.
    hdr = {2'b01, 2'b10, 5'h01, 5'h02};
    for (int i = 0; i < 32; i++) bitx(1'b1, o, t);
    for (int i = 13; i >= 0; i--) bitx(hdr[i], o, t);
    bitx(1'b1, o, t);
    bitx(1'b1, o, t);
    for (int i = 0; i < 8; i++) bitx(1'b1, o, t);
    mdc = 1'b0; mdi = 1'b1;
    #80;
    check("midread_mdt", mdt, 1'b0);
    check("midread_pre_a001", ext_a001, 16'h0100);
    rst = 1'b1;
    #1;
    check("midrst_mdt", mdt, 1'b1);
    check("midrst_mdo", mdo, 1'b1);
    #9;
    check("midrst_a001", ext_a001, 16'h0000);
    check("midrst_a003", ext_a003, 16'h0000);
    check("midrst_rxc_2ns", rxc_2ns, 1'b0);
    check("midrst_dlysel", rxc_dlysel, 4'h0);
    #20;
    rst = 1'b0;
    #40;
    frame(32, 2'b10, 5'h01, 5'h02, 16'h0000, rd, drove, ta0_t, ta1_o, ta1_t, rel_t);
    check("post_rst_id1", rd, 16'h001C);
    frame(32, 2'b10, 5'h01, 5'h1E, 16'h0000, rd, drove, ta0_t, ta1_o, ta1_t, rel_t);
    check("post_rst_ext_addr", rd, 16'h0000);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
